cpu_bus_arbiter: RTL and testbench
==================================

// Module: cpu_bus_arbiter
// PURPOSE
//  Shares the single CPU memory bus between instruction-cache port (I) and data-cache port (D).
//  Sits between CPU_ICache/CPU_DCache bus sides and the system bus; one owner at a time.
//  Request/ready protocol: level request held with address/data until a 1-cycle ready pulse.
// PARAMETERS
//  FIXED_PRIO    0  0 = round-robin on ties; 1 = D wins ties, subject to STARVE_LIMIT
//  STARVE_LIMIT  4  FIXED_PRIO=1 only: consecutive D grants while I waits before I is forced (1..15)
// PORTS
//  i_clock        in   1   system clock, all state on rising edge
//  i_reset_n      in   1   asynchronous active-low reset
//  i_i_request    in   1   I port request, held until o_i_ready
//  i_i_address    in   32  I port address (read-only port)
//  o_i_ready      out  1   I transfer complete, 1-cycle pulse
//  o_i_rdata      out  32  I read data, valid with o_i_ready
//  i_d_request    in   1   D port request, held until o_d_ready
//  i_d_rw         in   1   D direction, 1 = write
//  i_d_address    in   32  D address
//  i_d_wdata      in   32  D write data
//  o_d_ready      out  1   D transfer complete, 1-cycle pulse
//  o_d_rdata      out  32  D read data, valid with o_d_ready
//  o_bus_request  out  1   bus request
//  o_bus_rw       out  1   bus direction, 1 = write
//  o_bus_address  out  32  bus address
//  o_bus_wdata    out  32  bus write data
//  i_bus_ready    in   1   bus completion pulse
//  i_bus_rdata    in   32  bus read data, valid with i_bus_ready
// BEHAVIOUR
//  - States: IDLE, GRANT_I, GRANT_D. Registered state plus last_grant flag (reset = D, so I wins first tie).
//  - Reset (async, i_reset_n=0): state=IDLE, last_grant=D, starve_cnt=0.
//    All outputs 0 while in reset and in IDLE.
//  - IDLE: one request -> grant it next cycle.
//    Both requests -> FIXED_PRIO=0: the port not in last_grant; FIXED_PRIO=1: D, unless starve_cnt==STARVE_LIMIT -> I.
//  - GRANT_x: o_bus_request = i_x_request; o_bus_rw = i_d_rw for D, 0 for I; o_bus_address/o_bus_wdata muxed
//    combinationally from granted port; wdata=0 for I.
//  - Completion: i_bus_ready in GRANT_x -> o_x_ready=1 and o_x_rdata=i_bus_rdata, both in the same cycle (comb path).
//    last_grant<=x.
//  - Back-to-back: on completion, other port requesting -> go directly to GRANT_other. Otherwise -> IDLE.
//    Ties re-arbitrate per the IDLE rules; no dead cycle.
//  - Non-granted port: ready=0, rdata=0 at all times. i_bus_ready in IDLE is ignored.
//  - Abort: granted request drops before i_bus_ready -> o_bus_request drops the same cycle; state->IDLE next edge.
//    No ready pulse.
//  - starve_cnt (4 bit): +1 on each D grant while i_i_request=1; cleared on any I grant.
//    Saturates at STARVE_LIMIT.
//  - Min latency: request in IDLE -> bus request asserted next cycle -> ready the cycle bus responds.
//  - Reset mid-transfer: grant dropped immediately. A late i_bus_ready after reset is ignored (state IDLE).
// CONFIGURATION
//  - ARBITER_STATS_EN defined: adds o_i_grants, o_d_grants (32 bit each), counting completed transfers per port.
//    Wrap at 2^32; reset to 0.
//  - ARBITER_STATS_EN undefined: those ports exist but are tied 0, and no counter flops are built.
// TESTING
//  1. Reset, I only, addr 0x100, bus ready after 3 cycles with 0xDEADBEEF
//     -> o_bus_address=0x100, rw=0, o_i_ready 1 cycle, o_i_rdata=0xDEADBEEF.
//  2. I and D both request from IDLE, FIXED_PRIO=0 -> I first, then D with no idle cycle; next tie goes to I again.
//  3. D write addr 0x2000 data 0x55AA -> o_bus_rw=1, o_bus_wdata=0x55AA, o_d_ready pulses, o_i_ready stays 0.
//  4. FIXED_PRIO=1, STARVE_LIMIT=4, D and I both requesting continuously -> 4 D grants, then 1 I grant, pattern repeats.
//  5. D request dropped 1 cycle after grant, before bus ready -> o_bus_request=0 that cycle, no o_d_ready, IDLE next.
//  6. i_reset_n low during GRANT_I, then a late i_bus_ready -> no ready pulse. With ARBITER_STATS_EN: counters=0.

Source files
------------

// File: rtl/cpu_bus_arbiter_if.sv
// rtl/cpu_bus_arbiter_if.sv - I/D cache ports and system bus side of the CPU bus arbiter
//
// Purpose: bundles the instruction-cache port, data-cache port and system bus
// signals of cpu_bus_arbiter.
//   slave  modport : the arbiter's view (takes cache requests and bus responses)
//   master modport : the surrounding caches/bus view
// Signals:
//   i_i_request/i_i_address -> o_i_ready/o_i_rdata                      I port (read-only)
//   i_d_request/i_d_rw/i_d_address/i_d_wdata -> o_d_ready/o_d_rdata     D port
//   o_bus_request/o_bus_rw/o_bus_address/o_bus_wdata <- i_bus_ready/i_bus_rdata   system bus
interface cpu_bus_arbiter_if;
    logic        i_i_request;
    logic [31:0] i_i_address;
    logic        o_i_ready;
    logic [31:0] o_i_rdata;

    logic        i_d_request;
    logic        i_d_rw;
    logic [31:0] i_d_address;
    logic [31:0] i_d_wdata;
    logic        o_d_ready;
    logic [31:0] o_d_rdata;

    logic        o_bus_request;
    logic        o_bus_rw;
    logic [31:0] o_bus_address;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ready;
    logic [31:0] i_bus_rdata;

    modport slave (
        input  i_i_request, i_i_address,
        output o_i_ready, o_i_rdata,
        input  i_d_request, i_d_rw, i_d_address, i_d_wdata,
        output o_d_ready, o_d_rdata,
        output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
        input  i_bus_ready, i_bus_rdata
    );

    modport master (
        output i_i_request, i_i_address,
        input  o_i_ready, o_i_rdata,
        output i_d_request, i_d_rw, i_d_address, i_d_wdata,
        input  o_d_ready, o_d_rdata,
        input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
        output i_bus_ready, i_bus_rdata
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - shares the CPU memory bus between the I-cache and D-cache ports
//
// Purpose: one owner of the system bus at a time. A level request is held with
// its address/data until a one-cycle ready pulse; the bus response is routed
// combinationally back to the owner.
// Parameters:
//   FIXED_PRIO   0 = round-robin on ties, 1 = D wins ties unless I is starving
//   STARVE_LIMIT consecutive D grants while I waits before I is forced (1..15)
// Ports:
//   i_clock, i_reset_n        clock, asynchronous active-low reset
//   bus                       cpu_bus_arbiter_if.slave (I port, D port, system bus)
//   o_i_grants, o_d_grants    completed-transfer counters per port
// Optional feature macro: ARBITER_STATS_EN builds the transfer counters;
// without it the counter ports are tied to 0.
module cpu_bus_arbiter #(
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    cpu_bus_arbiter_if.slave   bus,
    output logic [31:0]        o_i_grants,
    output logic [31:0]        o_d_grants
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state, state_next;
    logic       last_grant_d, last_grant_d_next;
    logic [3:0] starve_cnt, starve_cnt_next;
    logic       grant_i, grant_d;

    // Winner of a simultaneous I/D request: round-robin favours the port that
    // was not served last; fixed priority favours D until I has waited out
    // STARVE_LIMIT D grants.
    function automatic logic tie_to_i(input logic last_was_d, input logic [3:0] cnt);
        if (FIXED_PRIO != 0)
            return (cnt == STARVE_MAX);
        return last_was_d;
    endfunction

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            starve_cnt   <= '0;
        end else begin
            state        <= state_next;
            last_grant_d <= last_grant_d_next;
            starve_cnt   <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next        = state;
        last_grant_d_next = last_grant_d;
        starve_cnt_next   = starve_cnt;
        grant_i           = 1'b0;
        grant_d           = 1'b0;
        bus.o_bus_request = 1'b0;
        bus.o_bus_rw      = 1'b0;
        bus.o_bus_address = '0;
        bus.o_bus_wdata   = '0;
        bus.o_i_ready     = 1'b0;
        bus.o_i_rdata     = '0;
        bus.o_d_ready     = 1'b0;
        bus.o_d_rdata     = '0;

        case (state)
            IDLE: begin
                if (bus.i_i_request && bus.i_d_request) begin
                    if (tie_to_i(last_grant_d, starve_cnt)) grant_i = 1'b1;
                    else                                    grant_d = 1'b1;
                end else if (bus.i_i_request) begin
                    grant_i = 1'b1;
                end else if (bus.i_d_request) begin
                    grant_d = 1'b1;
                end
            end

            GRANT_I: begin
                bus.o_bus_request = bus.i_i_request;
                bus.o_bus_address = bus.i_i_address;
                if (!bus.i_i_request) begin
                    // Owner withdrew before the bus answered: release, no ready.
                    state_next = IDLE;
                end else if (bus.i_bus_ready) begin
                    bus.o_i_ready     = 1'b1;
                    bus.o_i_rdata     = bus.i_bus_rdata;
                    last_grant_d_next = 1'b0;
                    state_next        = IDLE;
                    // Hand over without a dead cycle when D is waiting.
                    if (bus.i_d_request) begin
                        if (tie_to_i(1'b0, starve_cnt)) grant_i = 1'b1;
                        else                            grant_d = 1'b1;
                    end
                end
            end

            GRANT_D: begin
                bus.o_bus_request = bus.i_d_request;
                bus.o_bus_rw      = bus.i_d_rw;
                bus.o_bus_address = bus.i_d_address;
                bus.o_bus_wdata   = bus.i_d_wdata;
                if (!bus.i_d_request) begin
                    state_next = IDLE;
                end else if (bus.i_bus_ready) begin
                    bus.o_d_ready     = 1'b1;
                    bus.o_d_rdata     = bus.i_bus_rdata;
                    last_grant_d_next = 1'b1;
                    state_next        = IDLE;
                    if (bus.i_i_request) begin
                        if (tie_to_i(1'b1, starve_cnt)) grant_i = 1'b1;
                        else                            grant_d = 1'b1;
                    end
                end
            end

            default: state_next = IDLE;
        endcase

        if (grant_i) begin
            state_next      = GRANT_I;
            starve_cnt_next = '0;
        end
        if (grant_d) begin
            state_next = GRANT_D;
            // Only D grants that make a waiting I port wait longer count.
            if (bus.i_i_request && (starve_cnt != STARVE_MAX))
                starve_cnt_next = starve_cnt + 4'd1;
        end
    end

`ifdef ARBITER_STATS_EN
    logic [31:0] i_grants_q, d_grants_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            i_grants_q <= '0;
            d_grants_q <= '0;
        end else begin
            if (bus.o_i_ready) i_grants_q <= i_grants_q + 32'd1;
            if (bus.o_d_ready) d_grants_q <= d_grants_q + 32'd1;
        end
    end

    assign o_i_grants = i_grants_q;
    assign o_d_grants = d_grants_q;
`else
    assign o_i_grants = '0;
    assign o_d_grants = '0;
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - self-checking bench for cpu_bus_arbiter
module tb_cpu_bus_arbiter;

`ifdef ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_bus_arbiter_if if_rr ();
    cpu_bus_arbiter_if if_fp ();
    logic [31:0] r_ig, r_dg, f_ig, f_dg;

    cpu_bus_arbiter #(.FIXED_PRIO(0), .STARVE_LIMIT(4)) dut_rr (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .bus        (if_rr),
        .o_i_grants (r_ig),
        .o_d_grants (r_dg)
    );

    cpu_bus_arbiter #(.FIXED_PRIO(1), .STARVE_LIMIT(4)) dut_fp (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .bus        (if_fp),
        .o_i_grants (f_ig),
        .o_d_grants (f_dg)
    );

    // Reference model state for the round-robin instance.
    int m_owner;      // 0 = nobody, 1 = I, 2 = D
    bit m_last_d;
    int m_ic, m_dc;
    bit m_i_done, m_d_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_rr(input string tag, input logic breq, input logic rw,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic ir, input logic [31:0] irdata,
                          input logic dr, input logic [31:0] drdata);
        chk({tag, ".bus_request"}, 32'(if_rr.o_bus_request), 32'(breq));
        chk({tag, ".bus_rw"},      32'(if_rr.o_bus_rw),      32'(rw));
        chk({tag, ".bus_address"}, if_rr.o_bus_address,      addr);
        chk({tag, ".bus_wdata"},   if_rr.o_bus_wdata,        wdata);
        chk({tag, ".i_ready"},     32'(if_rr.o_i_ready),     32'(ir));
        chk({tag, ".i_rdata"},     if_rr.o_i_rdata,          irdata);
        chk({tag, ".d_ready"},     32'(if_rr.o_d_ready),     32'(dr));
        chk({tag, ".d_rdata"},     if_rr.o_d_rdata,          drdata);
    endtask

    task automatic chk_rr_zero(input string tag);
        chk_rr(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        if_rr.i_i_request = 1'b0; if_rr.i_i_address = '0;
        if_rr.i_d_request = 1'b0; if_rr.i_d_rw = 1'b0;
        if_rr.i_d_address = '0;   if_rr.i_d_wdata = '0;
        if_rr.i_bus_ready = 1'b0; if_rr.i_bus_rdata = '0;
        if_fp.i_i_request = 1'b0; if_fp.i_i_address = '0;
        if_fp.i_d_request = 1'b0; if_fp.i_d_rw = 1'b0;
        if_fp.i_d_address = '0;   if_fp.i_d_wdata = '0;
        if_fp.i_bus_ready = 1'b0; if_fp.i_bus_rdata = '0;
    endtask

    // Called at a drive point; returns at the next drive point out of reset.
    task automatic do_reset();
        rst_n = 1'b0;
        clr_inputs();
        drive_edge();
        rst_n = 1'b1;
        m_owner  = 0;
        m_last_d = 1'b1;
        m_ic = 0;
        m_dc = 0;
        m_i_done = 1'b0;
        m_d_done = 1'b0;
    endtask

    // One cycle of the round-robin reference: expected outputs from the
    // current owner and inputs, then the ownership decision for the next cycle.
    task automatic model_cycle();
        logic        eb, erw, ei, ed;
        logic [31:0] ea, ew, eir, edr;
        eb = 1'b0; erw = 1'b0; ei = 1'b0; ed = 1'b0;
        ea = '0; ew = '0; eir = '0; edr = '0;
        if (m_owner == 1) begin
            eb = if_rr.i_i_request;
            ea = if_rr.i_i_address;
            if (if_rr.i_i_request && if_rr.i_bus_ready) begin
                ei = 1'b1; eir = if_rr.i_bus_rdata;
            end
        end else if (m_owner == 2) begin
            eb = if_rr.i_d_request;
            erw = if_rr.i_d_rw;
            ea = if_rr.i_d_address;
            ew = if_rr.i_d_wdata;
            if (if_rr.i_d_request && if_rr.i_bus_ready) begin
                ed = 1'b1; edr = if_rr.i_bus_rdata;
            end
        end
        chk_rr("rnd", eb, erw, ea, ew, ei, eir, ed, edr);

        m_i_done = ei;
        m_d_done = ed;
        if (ei) m_ic++;
        if (ed) m_dc++;
        if (m_owner == 0) begin
            if (if_rr.i_i_request && if_rr.i_d_request) m_owner = m_last_d ? 1 : 2;
            else if (if_rr.i_i_request)                 m_owner = 1;
            else if (if_rr.i_d_request)                 m_owner = 2;
        end else if (m_owner == 1) begin
            if (!if_rr.i_i_request) m_owner = 0;
            else if (ei) begin
                m_last_d = 1'b0;
                m_owner = if_rr.i_d_request ? 2 : 0;
            end
        end else begin
            if (!if_rr.i_d_request) m_owner = 0;
            else if (ed) begin
                m_last_d = 1'b1;
                m_owner = if_rr.i_i_request ? 1 : 0;
            end
        end
    endtask

    initial begin
        clr_inputs();
        rst_n = 1'b0;

        // Reset: outputs stay 0 even with requests and bus ready asserted.
        if_rr.i_i_request = 1'b1; if_rr.i_d_request = 1'b1;
        if_rr.i_bus_ready = 1'b1; if_rr.i_bus_rdata = 32'hFFFF_FFFF;
        sample();
        chk_rr_zero("reset");
        chk("reset.i_grants", r_ig, 32'h0);
        chk("reset.d_grants", r_dg, 32'h0);
        drive_edge();
        clr_inputs();
        rst_n = 1'b1;

        // 1: I-only read, bus answers on the third granted cycle.
        drive_edge();
        if_rr.i_i_request = 1'b1; if_rr.i_i_address = 32'h100;
        sample(); chk_rr_zero("t1.idle");
        drive_edge();
        sample(); chk_rr("t1.grant", 1, 0, 32'h100, 0, 0, 0, 0, 0);
        drive_edge();
        sample(); chk_rr("t1.wait", 1, 0, 32'h100, 0, 0, 0, 0, 0);
        drive_edge();
        if_rr.i_bus_ready = 1'b1; if_rr.i_bus_rdata = 32'hDEAD_BEEF;
        sample(); chk_rr("t1.ready", 1, 0, 32'h100, 0, 1, 32'hDEAD_BEEF, 0, 0);
        drive_edge();
        if_rr.i_i_request = 1'b0; if_rr.i_bus_ready = 1'b0;
        sample(); chk_rr_zero("t1.done");
        drive_edge();

        // 2: tie from reset goes to I, D follows with no idle cycle, next tie to I.
        do_reset();
        if_rr.i_i_request = 1'b1; if_rr.i_i_address = 32'h200;
        if_rr.i_d_request = 1'b1; if_rr.i_d_address = 32'h300; if_rr.i_d_wdata = 32'h1234;
        sample(); chk_rr_zero("t2.idle");
        drive_edge();
        if_rr.i_bus_ready = 1'b1; if_rr.i_bus_rdata = 32'h1111_1111;
        sample(); chk_rr("t2.i", 1, 0, 32'h200, 0, 1, 32'h1111_1111, 0, 0);
        drive_edge();
        if_rr.i_i_request = 1'b0; if_rr.i_bus_rdata = 32'h2222_2222;
        sample(); chk_rr("t2.d", 1, 0, 32'h300, 32'h1234, 0, 0, 1, 32'h2222_2222);
        drive_edge();
        if_rr.i_d_request = 1'b0; if_rr.i_bus_ready = 1'b0;
        sample(); chk_rr_zero("t2.gap");
        drive_edge();
        if_rr.i_i_request = 1'b1; if_rr.i_d_request = 1'b1;
        sample(); chk_rr_zero("t2.tie_idle");
        drive_edge();
        if_rr.i_bus_ready = 1'b1; if_rr.i_bus_rdata = 32'h3333_3333;
        sample(); chk_rr("t2.tie_i", 1, 0, 32'h200, 0, 1, 32'h3333_3333, 0, 0);
        drive_edge();
        if_rr.i_i_request = 1'b0; if_rr.i_bus_rdata = 32'h4444_4444;
        sample(); chk_rr("t2.tie_d", 1, 0, 32'h300, 32'h1234, 0, 0, 1, 32'h4444_4444);

        // 3: D write.
        drive_edge();
        if_rr.i_bus_ready = 1'b0;
        if_rr.i_d_request = 1'b1; if_rr.i_d_rw = 1'b1;
        if_rr.i_d_address = 32'h2000; if_rr.i_d_wdata = 32'h55AA;
        sample(); chk_rr_zero("t3.idle");
        drive_edge();
        sample(); chk_rr("t3.grant", 1, 1, 32'h2000, 32'h55AA, 0, 0, 0, 0);
        drive_edge();
        if_rr.i_bus_ready = 1'b1; if_rr.i_bus_rdata = 32'h0BAD_F00D;
        sample(); chk_rr("t3.ready", 1, 1, 32'h2000, 32'h55AA, 0, 0, 1, 32'h0BAD_F00D);
        drive_edge();
        if_rr.i_d_request = 1'b0; if_rr.i_d_rw = 1'b0; if_rr.i_bus_ready = 1'b0;
        sample(); chk_rr_zero("t3.done");

        // 5: D request withdrawn one cycle after grant.
        drive_edge();
        if_rr.i_d_request = 1'b1; if_rr.i_d_address = 32'h44; if_rr.i_d_wdata = 32'h0;
        sample(); chk_rr_zero("t5.idle");
        drive_edge();
        sample(); chk_rr("t5.grant", 1, 0, 32'h44, 0, 0, 0, 0, 0);
        drive_edge();
        if_rr.i_d_request = 1'b0;
        sample();
        chk("t5.abort.bus_request", 32'(if_rr.o_bus_request), 32'h0);
        chk("t5.abort.d_ready", 32'(if_rr.o_d_ready), 32'h0);
        chk("t5.abort.i_ready", 32'(if_rr.o_i_ready), 32'h0);
        drive_edge();
        if_rr.i_bus_ready = 1'b1; if_rr.i_bus_rdata = 32'h5555;
        sample(); chk_rr_zero("t5.after");
        drive_edge();
        if_rr.i_bus_ready = 1'b0;
        chk("stats.i_grants", r_ig, STATS ? 32'd2 : 32'd0);
        chk("stats.d_grants", r_dg, STATS ? 32'd3 : 32'd0);

        // 6: reset during GRANT_I, then a late bus ready.
        if_rr.i_i_request = 1'b1; if_rr.i_i_address = 32'h600;
        sample(); chk_rr_zero("t6.idle");
        drive_edge();
        sample(); chk_rr("t6.grant", 1, 0, 32'h600, 0, 0, 0, 0, 0);
        drive_edge();
        rst_n = 1'b0;
        sample(); chk_rr_zero("t6.in_reset");
        drive_edge();
        rst_n = 1'b1; if_rr.i_i_request = 1'b0;
        if_rr.i_bus_ready = 1'b1; if_rr.i_bus_rdata = 32'h6666;
        sample(); chk_rr_zero("t6.late_ready");
        chk("t6.i_grants", r_ig, 32'h0);
        chk("t6.d_grants", r_dg, 32'h0);
        drive_edge();
        if_rr.i_bus_ready = 1'b0;

        // 4: fixed priority with continuous requests: D,D,D,D,I repeating.
        if_fp.i_i_request = 1'b1; if_fp.i_i_address = 32'h700;
        if_fp.i_d_request = 1'b1; if_fp.i_d_address = 32'h800;
        if_fp.i_bus_ready = 1'b1;
        sample();
        chk("t4.idle.i_ready", 32'(if_fp.o_i_ready), 32'h0);
        chk("t4.idle.d_ready", 32'(if_fp.o_d_ready), 32'h0);
        for (int k = 0; k < 10; k++) begin
            logic exp_i;
            drive_edge();
            if_fp.i_bus_rdata = 32'(k + 1);
            exp_i = ((k % 5) == 4);
            sample();
            chk("t4.i_ready", 32'(if_fp.o_i_ready), 32'(exp_i));
            chk("t4.d_ready", 32'(if_fp.o_d_ready), 32'(!exp_i));
            chk("t4.address", if_fp.o_bus_address, exp_i ? 32'h700 : 32'h800);
            chk("t4.rdata", exp_i ? if_fp.o_i_rdata : if_fp.o_d_rdata, 32'(k + 1));
        end
        drive_edge();
        if_fp.i_i_request = 1'b0; if_fp.i_d_request = 1'b0; if_fp.i_bus_ready = 1'b0;
        sample();
        chk("t4.released", 32'(if_fp.o_bus_request), 32'h0);
        chk("t4.i_grants", f_ig, STATS ? 32'd2 : 32'd0);
        chk("t4.d_grants", f_dg, STATS ? 32'd8 : 32'd0);
        drive_edge();

        // Randomized traffic on the round-robin instance against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!if_rr.i_i_request) begin
                if ($urandom_range(0, 9) < 4) begin
                    if_rr.i_i_request = 1'b1;
                    if_rr.i_i_address = $urandom;
                end
            end else if (m_i_done) begin
                if_rr.i_i_request = 1'b0;
            end else if (m_owner == 1 && $urandom_range(0, 19) == 0) begin
                if_rr.i_i_request = 1'b0;
            end
            if (!if_rr.i_d_request) begin
                if ($urandom_range(0, 9) < 4) begin
                    if_rr.i_d_request = 1'b1;
                    if_rr.i_d_rw      = 1'($urandom_range(0, 1));
                    if_rr.i_d_address = $urandom;
                    if_rr.i_d_wdata   = $urandom;
                end
            end else if (m_d_done) begin
                if_rr.i_d_request = 1'b0;
            end else if (m_owner == 2 && $urandom_range(0, 19) == 0) begin
                if_rr.i_d_request = 1'b0;
            end
            if_rr.i_bus_rdata = $urandom;
            if_rr.i_bus_ready = ($urandom_range(0, 2) == 0);
            if ((m_owner == 1 && !if_rr.i_i_request) || (m_owner == 2 && !if_rr.i_d_request))
                if_rr.i_bus_ready = 1'b0;
            sample();
            model_cycle();
            drive_edge();
        end
        chk("rnd.i_grants", r_ig, STATS ? 32'(m_ic) : 32'd0);
        chk("rnd.d_grants", r_dg, STATS ? 32'(m_dc) : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
